ssd_scan_decoder: RTL and testbench

Receive-side counterpart of the multiplexed 8-digit common-anode 7-segment driver.
Samples the scanned anode/segment bus (from a Pmod loopback or an external board) and reconstructs the per-digit values.
Reports frame completion, segment-pattern errors and whether digits 5..0 form a legal HH:MM:SS time.
Used on-FPGA as a self-check of the clock display path.

---
 rtl/ssd_pkg.sv | 51 +++++
 rtl/ssd_seg_to_hex.sv | 37 +++
 rtl/ssd_scan_decoder.sv | 141 ++++++++++++++
 tb/tb_ssd_scan_decoder.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// Shared constants for the 7-segment scan decoder: segment codes, slot map, time legality check.
package ssd_pkg;

    localparam int NUM_SLOTS  = 8;
    localparam int TIME_SLOTS = 6;

    // Slot indices of the HH:MM:SS digits, rightmost digit in slot 0
    localparam int S2 = 0;
    localparam int S1 = 1;
    localparam int M2 = 2;
    localparam int M1 = 3;
    localparam int H2 = 4;
    localparam int H1 = 5;

    localparam logic [7:0] AN_BLANK = 8'hFF;

    // Active-low segment codes, bit order {a,b,c,d,e,f,g}
    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0000100;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b1100000;
    localparam logic [6:0] SEG_C = 7'b0110001;
    localparam logic [6:0] SEG_D = 7'b1000010;
    localparam logic [6:0] SEG_E = 7'b0110000;
    localparam logic [6:0] SEG_F = 7'b0111000;

    // Hour 24 is accepted: the display shows 24:xx:xx before it wraps
    function automatic logic time_legal(input logic [4*TIME_SLOTS-1:0] d,
                                        input logic [TIME_SLOTS-1:0]   v);
        logic [3:0] hr1, hr2, mn1, mn2, sc1, sc2;
        hr1 = d[4*H1 +: 4];
        hr2 = d[4*H2 +: 4];
        mn1 = d[4*M1 +: 4];
        mn2 = d[4*M2 +: 4];
        sc1 = d[4*S1 +: 4];
        sc2 = d[4*S2 +: 4];
        return (&v) && (hr1 <= 4'd2) &&
               ((hr1 == 4'd2) ? (hr2 <= 4'd4) : (hr2 <= 4'd9)) &&
               (mn1 <= 4'd5) && (mn2 <= 4'd9) &&
               (sc1 <= 4'd5) && (sc2 <= 4'd9);
    endfunction

endpackage

// File: rtl/ssd_seg_to_hex.sv
// Combinational active-low 7-segment pattern to digit decoder.
// Hex letters A..F are accepted only when SSD_DECODE_HEX_EN is defined.
module ssd_seg_to_hex
    import ssd_pkg::*;
(
    input  logic [6:0] seg,
    output logic       legal,
    output logic [3:0] value
);

    always_comb begin
        legal = 1'b1;
        value = 4'h0;
        case (seg)
            SEG_0: value = 4'h0;
            SEG_1: value = 4'h1;
            SEG_2: value = 4'h2;
            SEG_3: value = 4'h3;
            SEG_4: value = 4'h4;
            SEG_5: value = 4'h5;
            SEG_6: value = 4'h6;
            SEG_7: value = 4'h7;
            SEG_8: value = 4'h8;
            SEG_9: value = 4'h9;
`ifdef SSD_DECODE_HEX_EN
            SEG_A: value = 4'hA;
            SEG_B: value = 4'hB;
            SEG_C: value = 4'hC;
            SEG_D: value = 4'hD;
            SEG_E: value = 4'hE;
            SEG_F: value = 4'hF;
`endif
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/ssd_scan_decoder.sv
// Reconstructs digits from a multiplexed common-anode 7-segment scan bus and checks for HH:MM:SS.
// Define SSD_DECODE_HEX_EN to accept hex letters A..F as legal digits.
module ssd_scan_decoder
    import ssd_pkg::*;
#(
    parameter int SETTLE_CYCLES = 16,
    parameter int ERR_W         = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [7:0]       an_in,
    input  logic [6:0]       seg_in,
    output logic [31:0]      digits_out,
    output logic [7:0]       digit_valid,
    output logic             frame_done,
    output logic             time_valid,
    output logic             seg_error,
    output logic [ERR_W-1:0] err_count
);

    localparam int              CNT_W   = $clog2(SETTLE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE_CYCLES - 1);

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] x);
        return (&x) ? x : x + 1'b1;
    endfunction

    logic [14:0]          bus_p0, bus_p1, bus_p2;
    logic [CNT_W-1:0]     stable_cnt;
    logic                 captured;
    logic [NUM_SLOTS-1:0] seen_mask;

    logic                 changed, capture;
    logic [7:0]           an_low;
    logic                 one_hot, blank;
    logic [2:0]           slot;
    logic                 seg_legal;
    logic [3:0]           seg_value;

    logic [31:0]          digits_n;
    logic [7:0]           valid_n, seen_n;
    logic                 frame_n, time_n, err_n;

    // p0/p1: two-flop synchronizer; p2: previous synchronized sample
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus_p0 <= '1;
            bus_p1 <= '1;
            bus_p2 <= '1;
        end else begin
            bus_p0 <= {an_in, seg_in};
            bus_p1 <= bus_p0;
            bus_p2 <= bus_p1;
        end
    end

    assign changed = (bus_p1 != bus_p2);
    assign capture = (stable_cnt == CNT_MAX) && !captured;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stable_cnt <= '0;
            captured   <= 1'b0;
        end else if (changed) begin
            stable_cnt <= '0;
            captured   <= 1'b0;
        end else begin
            if (stable_cnt != CNT_MAX)
                stable_cnt <= stable_cnt + 1'b1;
            if (capture)
                captured <= 1'b1;
        end
    end

    // bus_p2 still holds the settled value even if the bus moves on this cycle
    ssd_seg_to_hex u_dec (
        .seg   (bus_p2[6:0]),
        .legal (seg_legal),
        .value (seg_value)
    );

    assign an_low  = ~bus_p2[14:7];
    assign blank   = (bus_p2[14:7] == AN_BLANK);
    assign one_hot = $onehot(an_low);

    always_comb begin
        slot = 3'd0;
        for (int k = 0; k < NUM_SLOTS; k++)
            if (an_low[k])
                slot = 3'(k);
    end

    always_comb begin
        digits_n = digits_out;
        valid_n  = digit_valid;
        seen_n   = seen_mask;
        frame_n  = 1'b0;
        err_n    = 1'b0;
        if (capture && !blank) begin
            if (!one_hot) begin
                err_n = 1'b1;
            end else if (!seg_legal) begin
                err_n         = 1'b1;
                valid_n[slot] = 1'b0;
            end else begin
                digits_n[{slot, 2'b00} +: 4] = seg_value;
                valid_n[slot]                = 1'b1;
                if (slot == 3'(S2) && seen_mask[TIME_SLOTS-1:0] == '1) begin
                    frame_n = 1'b1;
                    seen_n  = 8'h01;
                end else begin
                    seen_n[slot] = 1'b1;
                end
            end
        end
        time_n = frame_n && time_legal(digits_n[4*TIME_SLOTS-1:0], valid_n[TIME_SLOTS-1:0]);
    end

    // Registered result of the capture decision
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            digits_out  <= '0;
            digit_valid <= '0;
            seen_mask   <= '0;
            frame_done  <= 1'b0;
            time_valid  <= 1'b0;
            seg_error   <= 1'b0;
            err_count   <= '0;
        end else begin
            digits_out  <= digits_n;
            digit_valid <= valid_n;
            seen_mask   <= seen_n;
            frame_done  <= frame_n;
            time_valid  <= time_n;
            seg_error   <= err_n;
            if (err_n)
                err_count <= sat_inc(err_count);
        end
    end

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// Table-driven bench for ssd_scan_decoder; hex expectations follow SSD_DECODE_HEX_EN.
module tb_ssd_scan_decoder;

    localparam int ERR_W = 2;
    localparam int HOLD  = 40;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [7:0]       an_in = 8'hFF;
    logic [6:0]       seg_in = 7'h7F;
    logic [31:0]      digits_out;
    logic [7:0]       digit_valid;
    logic             frame_done, time_valid, seg_error;
    logic [ERR_W-1:0] err_count;

    ssd_scan_decoder #(.SETTLE_CYCLES(16), .ERR_W(ERR_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .an_in       (an_in),
        .seg_in      (seg_in),
        .digits_out  (digits_out),
        .digit_valid (digit_valid),
        .frame_done  (frame_done),
        .time_valid  (time_valid),
        .seg_error   (seg_error),
        .err_count   (err_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0]       an;
        logic [6:0]       seg;
        int               hold;
        int               fd;
        int               tv;
        int               se;
        bit               chk;
        logic [31:0]      dig;
        logic [7:0]       dv;
        logic [ERR_W-1:0] ec;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;
    int   tot_fd = 0, tot_tv = 0, tot_se = 0;

    always @(negedge clock) begin
        if (frame_done) tot_fd++;
        if (time_valid) tot_tv++;
        if (seg_error)  tot_se++;
    end

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0:  return 7'b0000001;
            1:  return 7'b1001111;
            2:  return 7'b0010010;
            3:  return 7'b0000110;
            4:  return 7'b1001100;
            5:  return 7'b0100100;
            6:  return 7'b0100000;
            7:  return 7'b0001111;
            8:  return 7'b0000000;
            9:  return 7'b0000100;
            10: return 7'b0001000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [7:0] an_of(input int k);
        logic [7:0] m;
        m = 8'h01 << k;
        return ~m;
    endfunction

    function automatic void add(input logic [7:0] an, input logic [6:0] seg, input int hold,
                                input int fd, input int tv, input int se, input bit chk,
                                input logic [31:0] dig, input logic [7:0] dv,
                                input logic [ERR_W-1:0] ec);
        vec_t v;
        v.an = an; v.seg = seg; v.hold = hold; v.fd = fd; v.tv = tv; v.se = se;
        v.chk = chk; v.dig = dig; v.dv = dv; v.ec = ec;
        vecs.push_back(v);
    endfunction

    function automatic void dg(input int slot, input int d);
        add(an_of(slot), seg_of(d), HOLD, 0, 0, 0, 1'b0, '0, '0, '0);
    endfunction

    function automatic void dgc(input int slot, input int d, input int fd, input int tv,
                                input logic [31:0] dig, input logic [7:0] dv,
                                input logic [ERR_W-1:0] ec);
        add(an_of(slot), seg_of(d), HOLD, fd, tv, 0, 1'b1, dig, dv, ec);
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s vec=%0d got=%h want=%h", name, idx, act, exp);
        end
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        int   fd0, tv0, se0;
        v   = vecs[i];
        fd0 = tot_fd;
        tv0 = tot_tv;
        se0 = tot_se;
        an_in  = v.an;
        seg_in = v.seg;
        repeat (v.hold) @(posedge clock);
        #1;
        check("frame_done_pulses", i, 32'(tot_fd - fd0), 32'(v.fd));
        check("time_valid_pulses", i, 32'(tot_tv - tv0), 32'(v.tv));
        check("seg_error_pulses",  i, 32'(tot_se - se0), 32'(v.se));
        if (v.chk) begin
            check("digits_out",  i, digits_out,         v.dig);
            check("digit_valid", i, 32'(digit_valid),   32'(v.dv));
            check("err_count",   i, 32'(err_count),     32'(v.ec));
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_digits_out"},  -1, digits_out,         32'h0);
        check({tag, "_digit_valid"}, -1, 32'(digit_valid),   32'h0);
        check({tag, "_frame_done"},  -1, 32'(frame_done),    32'h0);
        check({tag, "_time_valid"},  -1, 32'(time_valid),    32'h0);
        check({tag, "_seg_error"},   -1, 32'(seg_error),     32'h0);
        check({tag, "_err_count"},   -1, 32'(err_count),     32'h0);
    endtask

    initial begin
        int               a_end, b_end;
        int               hx_se;
        logic [31:0]      hx_dig;
        logic [7:0]       hx_dv;
        logic [ERR_W-1:0] hx_ec;

`ifdef SSD_DECODE_HEX_EN
        hx_se = 0; hx_dig = 32'h8A195959; hx_dv = 8'hFF; hx_ec = 2'd2;
`else
        hx_se = 1; hx_dig = 32'h87195959; hx_dv = 8'hBF; hx_ec = 2'd3;
`endif

        // Sweep 1 (no frame yet), sweep 2 (frame on slot 0)
        dgc(0, 6, 0, 0, 32'h00000006, 8'h01, 0);
        dg(1, 5); dg(2, 4); dg(3, 3); dg(4, 2); dg(5, 1); dg(6, 7);
        dgc(7, 8, 0, 0, 32'h87123456, 8'hFF, 0);
        dgc(0, 6, 1, 1, 32'h87123456, 8'hFF, 0);
        dg(1, 5); dg(2, 4); dg(3, 3); dg(4, 2); dg(5, 1); dg(6, 7);
        dgc(7, 8, 0, 0, 32'h87123456, 8'hFF, 0);
        // Short glitch to "8" on slot 3 is never captured
        add(an_of(3), seg_of(3), 20, 0, 0, 0, 1'b0, '0, '0, '0);
        add(an_of(3), seg_of(8), 5,  0, 0, 0, 1'b0, '0, '0, '0);
        add(an_of(3), seg_of(3), 25, 0, 0, 0, 1'b1, 32'h87123456, 8'hFF, 0);
        // Illegal blank pattern on slot 2 inside a frame
        dgc(0, 6, 1, 1, 32'h87123456, 8'hFF, 0);
        dg(1, 5); dg(2, 4);
        add(an_of(2), 7'b1111111, HOLD, 0, 0, 1, 1'b1, 32'h87123456, 8'hFB, 1);
        dg(3, 3); dg(4, 2); dg(5, 1);
        dgc(0, 6, 1, 0, 32'h87123456, 8'hFB, 1);
        dgc(2, 4, 0, 0, 32'h87123456, 8'hFF, 1);
        // Two anodes low
        add(8'hFC, seg_of(1), HOLD, 0, 0, 1, 1'b1, 32'h87123456, 8'hFF, 2);
        // 24:59:59 legal, 25:00:00 and 12:60:00 illegal, 19:59:59 legal
        dg(1, 5); dg(2, 9); dg(3, 5); dg(4, 4); dg(5, 2);
        dgc(0, 9, 1, 1, 32'h87245959, 8'hFF, 2);
        dg(1, 0); dg(2, 0); dg(3, 0); dg(4, 5); dg(5, 2);
        dgc(0, 0, 1, 0, 32'h87250000, 8'hFF, 2);
        dg(1, 0); dg(2, 0); dg(3, 6); dg(4, 2); dg(5, 1);
        dgc(0, 0, 1, 0, 32'h87126000, 8'hFF, 2);
        dg(1, 5); dg(2, 9); dg(3, 5); dg(4, 9); dg(5, 1);
        dgc(0, 9, 1, 1, 32'h87195959, 8'hFF, 2);
        // Hex "A" on slot 6, then error counter saturation
        add(an_of(6), seg_of(10), HOLD, 0, 0, hx_se, 1'b1, hx_dig, hx_dv, hx_ec);
        add(8'h00, seg_of(8), HOLD, 0, 0, 1, 1'b1, hx_dig, hx_dv, 2'd3);
        add(8'h7E, seg_of(0), HOLD, 0, 0, 1, 1'b1, hx_dig, hx_dv, 2'd3);
        a_end = vecs.size();
        // Partial frame that the reset must discard
        dg(1, 3); dg(2, 4); dg(3, 5);
        b_end = vecs.size();
        // After reset: slot 0 alone does not close a frame, a full sweep does
        dgc(4, 5, 0, 0, 32'h00050000, 8'h10, 0);
        dg(5, 1);
        dgc(0, 2, 0, 0, 32'h00150002, 8'h31, 0);
        dg(1, 3); dg(2, 4); dg(3, 5);
        dgc(0, 2, 1, 1, 32'h00155432, 8'h3F, 0);

        repeat (3) @(posedge clock);
        #1;
        check_zero("reset_hold");
        @(negedge clock);
        reset = 1'b0;
        repeat (30) @(posedge clock);
        #1;

        for (int i = 0; i < a_end; i++) run_vec(i);
        for (int i = a_end; i < b_end; i++) run_vec(i);

        // Asynchronous reset between clock edges clears everything at once
        an_in  = 8'hFF;
        seg_in = 7'h7F;
        repeat (5) @(posedge clock);
        #3 reset = 1'b1;
        #1;
        check_zero("async_reset");
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;

        for (int i = b_end; i < vecs.size(); i++) run_vec(i);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
